// File: rtl/music_player_mcu.sv
// music_player_mcu: playback sequencer for the music player.
// Turns debounced front-panel pulses (play_pause, next) and the song reader's
// song_done pulse into the play level and the one-cycle reset_play pulse, and
// owns the current song index (manual skip, auto-advance, repeat, wrap).
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   play_pause  1-cycle pulse, toggles playing/paused
//   next        1-cycle pulse, skip to next song (always lands paused)
//   song_done   1-cycle pulse, current song finished
//   repeat_en   level, replay current song on song_done
//   play        level, song reader may advance notes
//   reset_play  1-cycle pulse, clears song reader / note player position
//   song        current song index, 0..SONG_NUM-1
module music_player_mcu #(
  parameter int SONG_NUM = 4,
  parameter int SONG_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              next,
  input  logic              song_done,
  input  logic              repeat_en,
  output logic              play,
  output logic              reset_play,
  output logic [SONG_W-1:0] song
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_PAUSE = 3'd1,
    S_PLAY  = 3'd2,
    S_NEXT  = 3'd3,
    S_AUTO  = 3'd4
  } state_t;

  localparam logic [SONG_W-1:0] LAST = SONG_W'(SONG_NUM - 1);

  state_t            state;
  logic              auto_resume;  // AUTO exits to PLAY when set, else PAUSE
  logic [SONG_W-1:0] song_wrap;

  // Explicit compare against the last index so non-power-of-two counts wrap.
  assign song_wrap = (song == LAST) ? '0 : song + SONG_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RESET;
      play        <= 1'b0;
      reset_play  <= 1'b0;
      song        <= '0;
      auto_resume <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state      <= S_PAUSE;
          play       <= 1'b0;
          reset_play <= 1'b1;
        end
        S_PAUSE: begin
          reset_play <= 1'b0;
          play       <= 1'b0;
          if (next) begin
            state      <= S_NEXT;
            reset_play <= 1'b1;
            song       <= song_wrap;
          end else if (play_pause) begin
            state <= S_PLAY;
            play  <= 1'b1;
          end
        end
        S_PLAY: begin
          reset_play <= 1'b0;
          if (next) begin
            state      <= S_NEXT;
            play       <= 1'b0;
            reset_play <= 1'b1;
            song       <= song_wrap;
          end else if (song_done) begin
            // Song index is updated on entry so it is valid alongside reset_play.
            state      <= S_AUTO;
            play       <= 1'b0;
            reset_play <= 1'b1;
            if (repeat_en) begin
              auto_resume <= 1'b1;
            end else if (song == LAST) begin
              song        <= '0;
              auto_resume <= 1'b0;  // end of album: stop
            end else begin
              song        <= song + SONG_W'(1);
              auto_resume <= 1'b1;
            end
          end else if (play_pause) begin
            state <= S_PAUSE;
            play  <= 1'b0;
          end
        end
        S_NEXT: begin
          state      <= S_PAUSE;
          play       <= 1'b0;
          reset_play <= 1'b0;
        end
        S_AUTO: begin
          state      <= auto_resume ? S_PLAY : S_PAUSE;
          play       <= auto_resume;
          reset_play <= 1'b0;
        end
        default: begin
          // Illegal encoding: park paused and clear downstream position.
          state      <= S_PAUSE;
          play       <= 1'b0;
          reset_play <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_music_player_mcu.sv
// Bench for music_player_mcu (SONG_NUM=3 to exercise non-power-of-two wrap).
// Directed steps from the test plan followed by a randomized phase, all
// checked against a behavioural model of the playback rules.
module tb_music_player_mcu;

  localparam int N = 3;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         play_pause = 1'b0;
  logic         next = 1'b0;
  logic         song_done = 1'b0;
  logic         repeat_en = 1'b0;
  logic         play;
  logic         reset_play;
  logic [W-1:0] song;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: playing flag, song number, and a one-cycle "busy"
  // window after a skip/auto-advance during which inputs are dropped.
  bit m_play = 0;
  bit m_rp = 0;
  int m_song = 0;
  bit m_start = 1;   // first edge after reset release pending
  bit m_busy = 0;
  bit m_resume = 0;

  music_player_mcu #(.SONG_NUM(N), .SONG_W(W)) dut (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next),
    .song_done(song_done), .repeat_en(repeat_en),
    .play(play), .reset_play(reset_play), .song(song)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".play"}, int'(play), int'(m_play));
    chk({tag, ".reset_play"}, int'(reset_play), int'(m_rp));
    chk({tag, ".song"}, int'(song), m_song);
  endtask

  task automatic model_reset();
    m_play = 0; m_rp = 0; m_song = 0; m_start = 1; m_busy = 0; m_resume = 0;
  endtask

  task automatic model_edge(bit rst, bit pp, bit nx, bit sd, bit re);
    if (!rst) begin
      model_reset();
    end else if (m_start) begin
      m_start = 0; m_rp = 1; m_play = 0;
    end else if (m_busy) begin
      m_busy = 0; m_rp = 0; m_play = m_resume;
    end else if (nx) begin
      m_song = (m_song + 1) % N; m_rp = 1; m_play = 0; m_busy = 1; m_resume = 0;
    end else if (m_play && sd) begin
      if (re) m_resume = 1;
      else if (m_song == N - 1) begin m_song = 0; m_resume = 0; end
      else begin m_song = m_song + 1; m_resume = 1; end
      m_rp = 1; m_play = 0; m_busy = 1;
    end else if (pp) begin
      m_play = !m_play; m_rp = 0;
    end else begin
      m_rp = 0;
    end
  endtask

  // One clock: drive at negedge, model the rising edge, sample 1 time unit later.
  task automatic step(string tag, bit pp, bit nx, bit sd, bit re, bit rst = 1'b1);
    @(negedge clk);
    play_pause = pp; next = nx; song_done = sd; repeat_en = re; reset = rst;
    @(posedge clk);
    model_edge(rst, pp, nx, sd, re);
    #1;
    chk_all(tag);
  endtask

  // Assert reset between edges and check outputs clear without a clock edge.
  task automatic async_reset(string tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
  endtask

  initial begin
    // Reset held for 3 cycles.
    #1;
    chk_all("por");
    for (int i = 0; i < 3; i++) step("rst_hold", 0, 0, 0, 0, 1'b0);
    step("release", 0, 0, 0, 0);
    chk("release.rp_const", int'(reset_play), 1);
    chk("release.song_const", int'(song), 0);
    step("pause_idle", 0, 0, 0, 0);
    step("pp_start", 1, 0, 0, 0);
    chk("pp_start.play_const", int'(play), 1);

    // Walk to song 2, play, then manual skip wraps to 0 and lands paused.
    step("skip1", 0, 1, 0, 0);
    step("skip1_out", 0, 0, 0, 0);
    step("skip2", 0, 1, 0, 0);
    step("skip2_out", 0, 0, 0, 0);
    step("play2", 1, 0, 0, 0);
    step("wrap_skip", 0, 1, 0, 0);
    chk("wrap_skip.song_const", int'(song), 0);
    step("pp_in_next", 1, 0, 0, 0);      // dropped during NEXT
    step("stay_paused", 0, 0, 0, 0);
    chk("stay_paused.play_const", int'(play), 0);

    // song_done in PAUSE is ignored.
    step("done_paused", 0, 0, 1, 0);

    // Auto-advance 0->1->2, then end of album.
    step("play0", 1, 0, 0, 0);
    step("auto01", 0, 0, 1, 0);
    step("auto01_out", 0, 0, 0, 0);
    step("auto12", 0, 0, 1, 0);
    step("auto12_out", 0, 0, 0, 0);
    step("repeat2", 0, 0, 1, 1);         // repeat keeps song 2
    step("repeat2_out", 0, 1, 1, 1);     // next during AUTO is dropped
    step("album_end", 0, 0, 1, 0);
    chk("album_end.song_const", int'(song), 0);
    step("album_end_out", 0, 0, 0, 0);
    step("album_idle", 0, 0, 0, 0);

    // Simultaneous events in PLAY behave as next only.
    step("play_again", 1, 0, 0, 0);
    step("all_three", 1, 1, 1, 0);
    step("all_three_out", 0, 0, 0, 0);

    // Async reset mid-play with song 2.
    step("to_play", 1, 0, 0, 0);
    step("adv", 0, 0, 1, 0);
    step("adv_out", 0, 0, 0, 0);
    async_reset("async_mid");
    step("async_hold", 0, 0, 0, 0, 1'b0);
    step("async_release", 0, 0, 0, 0);
    step("async_after", 0, 0, 0, 0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd_async");
        step("rnd_hold", 0, 0, 0, 0, 1'b0);
      end else begin
        step("rnd",
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 30);
      end
    end
    step("final", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
